fe_mul_arbiter: RTL and testbench

FE_MUL_ARBITER -- requirements
Module: fe_mul_arbiter

---
 rtl/fe_mul_arbiter.sv | 90 +++++++++
 tb/tb_fe_mul_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fe_mul_arbiter.sv
// rtl/fe_mul_arbiter.sv - round-robin arbiter sharing one fe_mul unit among NREQ requesters
// Operands are captured at grant, so requesters may change them once busy.
module fe_mul_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NREQ-1:0]                        req,
  input  logic [NREQ*320-1:0]                    req_f,
  input  logic [NREQ*320-1:0]                    req_g,
  output logic [NREQ-1:0]                        ack,
  output logic [319:0]                           rsp_h,
  output logic                                   busy,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] owner,
  output logic                                   mul_start,
  output logic [319:0]                           mul_f,
  output logic [319:0]                           mul_g,
  input  logic [319:0]                           mul_h,
  input  logic                                   mul_done
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LW = 320;
  localparam logic [OW-1:0] LAST_RST = OW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [OW-1:0] last_grant;
  logic [OW-1:0] winner;
  logic [OW-1:0] idx_w;
  int            idx;

  // Walk offsets from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = int'(last_grant) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = OW'(idx);
      if (req[idx_w]) winner = idx_w;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ack        <= '0;
      busy       <= 1'b0;
      mul_start  <= 1'b0;
      owner      <= '0;
      last_grant <= LAST_RST;
      rsp_h      <= '0;
      mul_f      <= '0;
      mul_g      <= '0;
    end else begin
      mul_start <= 1'b0;
      ack       <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            mul_f     <= req_f[LW*winner +: LW];
            mul_g     <= req_g[LW*winner +: LW];
            owner     <= winner;
            busy      <= 1'b1;
            mul_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (mul_done) begin
            rsp_h      <= mul_h;
            ack        <= NREQ'(1) << owner;
            last_grant <= owner;
            state      <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// tb/tb_fe_mul_arbiter.sv - directed bench for fe_mul_arbiter with a limb-wise fe_mul model
module tb_fe_mul_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 320;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*W-1:0]   req_f = '0;
  logic [NREQ*W-1:0]   req_g = '0;
  logic [NREQ-1:0]     ack;
  logic [W-1:0]        rsp_h;
  logic                busy;
  logic [1:0]          owner;
  logic                mul_start;
  logic [W-1:0]        mul_f;
  logic [W-1:0]        mul_g;
  logic [W-1:0]        mul_h;
  logic                mul_done;

  always #5 clk = ~clk;

  fe_mul_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req(req), .req_f(req_f), .req_g(req_g),
    .ack(ack), .rsp_h(rsp_h), .busy(busy), .owner(owner),
    .mul_start(mul_start), .mul_f(mul_f), .mul_g(mul_g),
    .mul_h(mul_h), .mul_done(mul_done)
  );

  function automatic logic [W-1:0] limb_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = a[32*i +: 32] * b[32*i +: 32];
    return r;
  endfunction

  // fe_mul stand-in: product of the operands present when done fires, done in cycle 8 after start in cycle 1
  logic [3:0]   cnt;
  logic         model_done;
  logic         force_done = 1'b0;
  logic [W-1:0] model_h;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      model_done <= 1'b0;
      model_h    <= '0;
    end else begin
      model_done <= 1'b0;
      if (mul_start) cnt <= 4'd6;
      else if (cnt != 0) cnt <= cnt - 4'd1;
      if (cnt == 4'd1 && !mul_start) begin
        model_done <= 1'b1;
        model_h    <= limb_mul(mul_f, mul_g);
      end
    end
  end

  assign mul_done = model_done | force_done;
  assign mul_h    = model_h;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fill_ones();
    for (int s = 0; s < NREQ; s++)
      for (int j = 0; j < 10; j++) begin
        req_f[W*s + 32*j +: 32] = 32'd1;
        req_g[W*s + 32*j +: 32] = 32'd1;
      end
  endtask

  task automatic set_slot(input int s, input logic [31:0] f, input logic [31:0] g);
    req_f[W*s +: W] = W'(f);
    req_g[W*s +: W] = W'(g);
  endtask

  task automatic do_txn(input logic [NREQ-1:0] r, input int chg_cyc,
                        output int got_owner, output logic [NREQ-1:0] got_ack,
                        output logic [W-1:0] got_h, output int lat,
                        output int start_cyc, output bit busy_ok);
    busy_ok = 1'b1; start_cyc = -1; lat = -1; got_ack = '0; got_owner = -1; got_h = '0;
    @(negedge clk);
    req = r;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == chg_cyc) begin
        req_f[31:0] = 32'd100;
        req_g[31:0] = 32'd100;
      end
      if (mul_start && start_cyc < 0) start_cyc = c;
      if (!busy) busy_ok = 1'b0;
      if (ack != 0) begin
        lat = c; got_ack = ack; got_owner = int'(owner); got_h = rsp_h;
        break;
      end
    end
    req = '0;
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    logic [31:0]     f;
    logic [31:0]     g;
    int              owner;
    logic [31:0]     h;
  } vec_t;

  vec_t vecs[9];

  int              t_owner, t_lat, t_start;
  logic [NREQ-1:0] t_ack;
  logic [W-1:0]    t_h;
  bit              t_busy;
  int              seen, n_ack;
  int              served[NREQ];

  initial begin
    vecs[0] = '{4'b0001, 32'd2,          32'd3,     0, 32'd6};
    vecs[1] = '{4'b1111, 32'd5,          32'd7,     1, 32'd35};
    vecs[2] = '{4'b1010, 32'd11,         32'd13,    3, 32'd143};
    vecs[3] = '{4'b1010, 32'd100,        32'd200,   1, 32'd20000};
    vecs[4] = '{4'b0100, 32'hFFFF_FFFF,  32'd2,     2, 32'hFFFF_FFFE};
    vecs[5] = '{4'b0101, 32'd65536,      32'd65536, 0, 32'd0};
    vecs[6] = '{4'b1001, 32'd9,          32'd9,     3, 32'd81};
    vecs[7] = '{4'b1000, 32'd4,          32'd25,    3, 32'd100};
    vecs[8] = '{4'b0011, 32'd12,         32'd12,    0, 32'd144};

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_ack", W'(ack), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_start", W'(mul_start), '0);
    chk("rst_owner", W'(owner), '0);
    chk("rst_rsp_h", rsp_h, '0);
    chk("rst_mul_f", mul_f, '0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      fill_ones();
      set_slot(vecs[i].owner, vecs[i].f, vecs[i].g);
      do_txn(vecs[i].req, 0, t_owner, t_ack, t_h, t_lat, t_start, t_busy);
      chk($sformatf("v%0d_owner", i), W'(t_owner), W'(vecs[i].owner));
      chk($sformatf("v%0d_ack", i), W'(t_ack), W'(4'b0001 << vecs[i].owner));
      chk($sformatf("v%0d_rsp_h", i), t_h, W'(vecs[i].h));
      chk($sformatf("v%0d_ack_cycle", i), W'(t_lat), W'(9));
      chk($sformatf("v%0d_start_cycle", i), W'(t_start), W'(1));
      chk($sformatf("v%0d_busy", i), W'(t_busy), W'(1));
    end

    // operands changed while WAIT: product of values sampled at grant
    fill_ones();
    set_slot(0, 32'd7, 32'd9);
    do_txn(4'b0001, 3, t_owner, t_ack, t_h, t_lat, t_start, t_busy);
    chk("hold_owner", W'(t_owner), W'(0));
    chk("hold_rsp_h", t_h, W'(32'd63));

    // spurious mul_done in IDLE
    repeat (2) @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ack != 0 || busy || mul_start) seen++;
    end
    chk("spurious_done_quiet", W'(seen), W'(0));
    fill_ones();
    set_slot(1, 32'd6, 32'd7);
    do_txn(4'b0010, 0, t_owner, t_ack, t_h, t_lat, t_start, t_busy);
    chk("after_spurious_owner", W'(t_owner), W'(1));
    chk("after_spurious_rsp_h", t_h, W'(32'd42));
    chk("after_spurious_cycle", W'(t_lat), W'(9));

    // reset in WAIT discards the operation
    fill_ones();
    set_slot(0, 32'd3, 32'd4);
    @(negedge clk);
    req = 4'b0001;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("wrst_busy", W'(busy), '0);
    chk("wrst_ack", W'(ack), '0);
    chk("wrst_owner", W'(owner), '0);
    chk("wrst_mul_f", mul_f, '0);
    chk("wrst_rsp_h", rsp_h, '0);
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ack != 0) seen++;
    end
    chk("wrst_no_ack", W'(seen), W'(0));
    set_slot(0, 32'd5, 32'd6);
    do_txn(4'b1001, 0, t_owner, t_ack, t_h, t_lat, t_start, t_busy);
    chk("wrst_next_owner", W'(t_owner), W'(0));
    chk("wrst_next_rsp_h", t_h, W'(32'd30));
    chk("wrst_next_cycle", W'(t_lat), W'(9));

    // continuous contention from reset
    @(negedge clk);
    reset = 1'b0;
    fill_ones();
    for (int s = 0; s < NREQ; s++) begin
      set_slot(s, 32'(s + 2), 32'd10);
      served[s] = 0;
    end
    req = 4'b1111;
    @(negedge clk);
    reset = 1'b1;
    n_ack = 0;
    for (int c = 0; c < 200 && n_ack < 8; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        chk($sformatf("rr%0d_owner", n_ack), W'(owner), W'(n_ack % NREQ));
        chk($sformatf("rr%0d_ack", n_ack), W'(ack), W'(4'b0001 << (n_ack % NREQ)));
        chk($sformatf("rr%0d_rsp_h", n_ack), rsp_h, W'(32'((n_ack % NREQ + 2) * 10)));
        served[owner]++;
        n_ack++;
      end
    end
    req = '0;
    chk("rr_total", W'(n_ack), W'(8));
    for (int s = 0; s < NREQ; s++) chk($sformatf("rr_served%0d", s), W'(served[s]), W'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
